// File: rtl/fetch_controller.sv
// Instruction-fetch controller: owns the fetch PC, issues one outstanding imem request
// and buffers fetched words for decode. Optional macro FETCH_PERF_CNT_EN adds fetch_stall_cnt.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_offset,
    input  logic        halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_KILL
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic           r_req;
    logic [31:0]    r_addr;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [31:0]    r_mem_instr [BUF_DEPTH];
    logic [31:0]    r_mem_pc    [BUF_DEPTH];

    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_free;
    logic [31:0]    w_target;
    logic [31:0]    w_next_pc;

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign if_valid  = (r_count != '0);
    assign if_instr  = r_mem_instr[r_rd_ptr];
    assign if_pc     = r_mem_pc[r_rd_ptr];

    // Redirect outranks both FIFO ports: the flush wins over any same-cycle push or pop.
    assign w_pop     = if_valid && if_ready && !redirect_valid;
    assign w_push    = (r_state == ST_FETCH) && imem_ack && !redirect_valid;
    assign w_free    = DEPTH_C - r_count + CW'(w_pop);
    assign w_target  = redirect_base + 32'd4 + (redirect_offset << 2);
    assign w_next_pc = r_addr + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            // NOTE: storage is cleared so if_instr/if_pc read 0 out of reset, not X.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= imem_rdata;
                r_mem_pc[r_wr_ptr]    <= r_addr;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_target;
                    end else if (!halt && (w_free != '0)) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_target;
                        if (imem_ack) begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= ST_KILL;
                        end
                    end else if (imem_ack) begin
                        r_fetch_pc <= w_next_pc;
                        if (!halt && (w_free > CW'(1))) begin
                            r_addr <= w_next_pc;
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                ST_KILL: begin
                    // The killed request stays on the bus until acked; its data is dropped.
                    if (redirect_valid) begin
                        r_fetch_pc <= w_target;
                    end
                    if (imem_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_stall_cnt <= '0;
        end else if (r_req && !imem_ack) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller (BUF_DEPTH=2, RESET_PC=0).
module tb_fetch_controller;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_offset;
    logic        halt;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_controller #(.RESET_PC(32'd0), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .redirect_valid  (redirect_valid),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .halt            (halt)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    // Memory returns a word derived from the address so each fetched word is distinguishable.
    assign imem_rdata = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack, input logic rdy);
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_base   = '0;
        redirect_offset = '0;
        halt            = 1'b0;
        imem_ack        = ack;
        if_ready        = rdy;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] base, input logic [31:0] off);
        redirect_valid  = 1'b1;
        redirect_base   = base;
        redirect_offset = off;
    endtask

    initial begin
        do_reset(1'b1, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc",    if_pc, 32'd0);

        // Streaming with ack=1, if_ready=1: one instruction per cycle
        do_reset(1'b1, 1'b1);
        tick();
        check("s_req0",   {31'd0, imem_req}, 32'd1);
        check("s_addr0",  imem_addr, 32'd0);
        check("s_valid0", {31'd0, if_valid}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("s_addr",  imem_addr, 32'(4 * i));
            check("s_valid", {31'd0, if_valid}, 32'd1);
            check("s_pc",    if_pc, 32'(4 * (i - 1)));
            check("s_instr", if_instr, 32'(4 * (i - 1)) ^ KEY);
        end

        // Backpressure fills the 2-entry FIFO, then fetch resumes at PC 8
        do_reset(1'b1, 1'b0);
        tick();
        tick();
        check("bp_addr1", imem_addr, 32'd4);
        tick();
        check("bp_req_off", {31'd0, imem_req}, 32'd0);
        check("bp_head",    if_pc, 32'd0);
        tick();
        check("bp_idle",    {31'd0, imem_req}, 32'd0);
        if_ready = 1'b1;
        tick();
        check("bp_resume_req",  {31'd0, imem_req}, 32'd1);
        check("bp_resume_addr", imem_addr, 32'd8);
        check("bp_head2",       if_pc, 32'd4);

        // Redirect during outstanding request -> KILL, stale ack discarded
        do_reset(1'b1, 1'b0);
        tick();
        tick();
        imem_ack = 1'b0;
        tick();
        check("k_wait_valid", {31'd0, if_valid}, 32'd1);
        redirect(32'h10, 32'd3);
        tick();
        redirect_valid = 1'b0;
        check("k_flush",    {31'd0, if_valid}, 32'd0);
        check("k_req_hold", {31'd0, imem_req}, 32'd1);
        check("k_addr",     imem_addr, 32'd4);
        tick();
        imem_ack = 1'b1;
        tick();
        check("k_drop_req",   {31'd0, imem_req}, 32'd0);
        check("k_drop_valid", {31'd0, if_valid}, 32'd0);
        if_ready = 1'b1;
        tick();
        check("k_new_addr", imem_addr, 32'h20);
        tick();
        check("k_new_pc",    if_pc, 32'h20);
        check("k_new_instr", if_instr, 32'h20 ^ KEY);

        // Redirect coinciding with ack, negative offset
        do_reset(1'b1, 1'b1);
        tick();
        tick();
        redirect(32'h40, 32'hFFFF_FFFF);
        tick();
        redirect_valid = 1'b0;
        check("ra_valid", {31'd0, if_valid}, 32'd0);
        check("ra_req",   {31'd0, imem_req}, 32'd0);
        tick();
        check("ra_addr", imem_addr, 32'h40);
        tick();
        check("ra_pc", if_pc, 32'h40);

        // PC wrap at the top of the address space, then halt mid-wait
        do_reset(1'b0, 1'b1);
        tick();
        redirect(32'hFFFF_FFF4, 32'd1);
        imem_ack = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("w_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("w_addr_wrap", imem_addr, 32'd0);
        check("w_pc",        if_pc, 32'hFFFF_FFFC);
        imem_ack = 1'b0;
        halt     = 1'b1;
        tick();
        check("h_req_held", {31'd0, imem_req}, 32'd1);
        check("h_addr",     imem_addr, 32'd0);
        imem_ack = 1'b1;
        tick();
        check("h_pushed",   {31'd0, if_valid}, 32'd1);
        check("h_pushed_pc", if_pc, 32'd0);
        check("h_req_off",  {31'd0, imem_req}, 32'd0);
        tick();
        check("h_stays_off", {31'd0, imem_req}, 32'd0);

        // Asynchronous reset mid-FETCH
        halt = 1'b0;
        tick();
        tick();
        check("ar_pre_req", {31'd0, imem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_req",   {31'd0, imem_req}, 32'd0);
        check("ar_addr",  imem_addr, 32'd0);
        check("ar_valid", {31'd0, if_valid}, 32'd0);
        check("ar_instr", if_instr, 32'd0);
        check("ar_pc",    if_pc, 32'd0);

`ifdef FETCH_PERF_CNT_EN
        // Two requests with three stall cycles each
        do_reset(1'b0, 1'b1);
        check("pc_rst", fetch_stall_cnt, 32'd0);
        tick();
        check("pc_start", fetch_stall_cnt, 32'd0);
        tick();
        tick();
        tick();
        imem_ack = 1'b1;
        tick();
        check("pc_first", fetch_stall_cnt, 32'd3);
        imem_ack = 1'b0;
        tick();
        tick();
        tick();
        imem_ack = 1'b1;
        halt     = 1'b1;
        tick();
        tick();
        check("pc_total", fetch_stall_cnt, 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Instruction-fetch controller between the PC datapath and instruction memory. It owns the fetch PC and issues at most one outstanding imem request through a req/ack handshake. Fetched words go into a small FIFO consumed by decode through a valid/ready handshake. Branch redirects are applied with the codebase's PC-relative rule, and stale in-flight data is discarded.

Parameters:
RESET_PC, 32'd0, fetch address after reset
BUF_DEPTH, 2, instruction FIFO entries; power of 2, >=2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
imem_req  output  1  fetch request
imem_addr  output  32  byte address of request
imem_ack  input  1  request completes this cycle
imem_rdata  input  32  instruction word, valid when imem_req && imem_ack
if_valid  output  1  FIFO head valid
if_instr  output  32  FIFO head instruction
if_pc  output  32  FIFO head byte PC
if_ready  input  1  decode accepts head
redirect_valid  input  1  branch taken / redirect
redirect_base  input  32  PC of branch instruction
redirect_offset  input  32  signed word offset
halt  input  1  stop issuing new requests

Behaviour:
- Reset (reset==0, async): state=IDLE, fetch_pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, FIFO count=0, FIFO storage=0, if_valid=0, if_instr=0, if_pc=0.
- Redirect target = redirect_base + 4 + (redirect_offset << 2), modulo 2^32. No alignment check.
- Handshake: a request completes on a cycle with imem_req && imem_ack. Once raised, imem_req stays high and imem_addr stays stable until ack. A request is never retracted.
- free = BUF_DEPTH - count + (pop ? 1 : 0), where pop = if_valid && if_ready && !redirect_valid.
- FSM:
  IDLE: imem_req=0. If !halt && !redirect_valid && free>0 -> FETCH, imem_addr<=fetch_pc.
  FETCH: imem_req=1.
    - ack && !redirect_valid: push {imem_addr, imem_rdata}; fetch_pc<=imem_addr+4, wrapping 32'hFFFFFFFC -> 0. Stay in FETCH with the new address if !halt && free-1>0, else -> IDLE.
    - ack && redirect_valid: drop data; fetch_pc<=target; -> IDLE.
    - !ack && redirect_valid: fetch_pc<=target; -> KILL. imem_addr is held.
  KILL: imem_req=1 on the old address. On ack, drop data -> IDLE. A further redirect only updates fetch_pc.
- Redirect in any state flushes the FIFO (count<=0) and has priority over push and pop. if_valid is 0 the next cycle.
- FIFO: if_valid = (count!=0); if_instr and if_pc come from the head entry. Simultaneous push and pop keeps count unchanged. Push never occurs when full, which the free check guarantees.
- Latency: first imem_req is high in the cycle after reset release. With ack in that cycle, if_valid is high the next cycle. Sustained throughput is 1 instruction/cycle with single-cycle ack and if_ready=1.
- halt does not abort an outstanding request. That data is still pushed unless a redirect occurs.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds output port fetch_stall_cnt[31:0]. It resets to 0 and increments, wrapping, on every cycle with imem_req && !imem_ack. When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, ack tied 1, if_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; if_pc/if_instr follow one cycle later; no bubbles.
- if_ready=0, ack=1, BUF_DEPTH=2 -> two pushes (PC 0,4), then imem_req=0 and count=2. Raise if_ready -> fetch resumes at PC 8.
- Redirect base=0x10, offset=3 while FETCH with ack=0 -> KILL; the ack 2 cycles later is discarded; next request addr=0x20; FIFO empty the cycle after redirect.
- Redirect with ack in the same cycle (base=0x40, offset=-1) -> data dropped; next request at 0x40; if_valid=0 next cycle.
- Fetch PC 0xFFFFFFFC acked -> next imem_addr=0. halt=1 mid-wait -> outstanding ack still pushed, then imem_req stays 0. Async reset mid-FETCH -> all outputs at reset values immediately.
- With FETCH_PERF_CNT_EN, ack delayed 3 cycles per request over 2 requests -> fetch_stall_cnt=6.
